// File: rtl/uart_frame_tx.sv
// Outbound host-link framer: drains fifo2 into one SOF/payload/checksum/EOF
// packet, byte-stuffing markers, and hands each byte to the UART TX core.
module uart_frame_tx #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic             clk_100,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_valid,
  output logic             rd_en,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [7:0] SOF     = 8'hFF;
  localparam logic [7:0] EOF     = 8'hFE;
  localparam logic [7:0] ESC     = 8'hFD;
  localparam logic [7:0] ESC_XOR = 8'h20;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE, SEND, WAIT_TX, FETCH, WAIT_RD, ESC2, CSUM, EOF_S, FIN
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;          // where to go once the UART byte completes
  state_t           esc_ret_q, esc_ret_d;  // where to go after the second escape byte
  logic [7:0]       tx_data_d;
  logic [7:0]       esc_byte_q, esc_byte_d;
  logic [7:0]       csum_q, csum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] byte_count_d;
  logic             guard_q, guard_d;

  logic [7:0]       out_byte;
  state_t           out_next;

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == SOF) || (b == EOF) || (b == ESC);
  endfunction

  // Payload bytes and the checksum share the same escape path.
  assign out_byte = (state_q == CSUM) ? csum_q : fifo_dout;
  assign out_next = (state_q == CSUM) ? EOF_S : FETCH;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    ret_d        = ret_q;
    esc_ret_d    = esc_ret_q;
    tx_data_d    = tx_data;
    esc_byte_d   = esc_byte_q;
    csum_d       = csum_q;
    count_d      = count_q;
    byte_count_d = byte_count;
    guard_d      = guard_q;
    rd_en        = 1'b0;
    tx_en        = 1'b0;
    done         = 1'b0;
    busy         = (state_q != IDLE) && (state_q != FIN);

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_data_d = SOF;
          ret_d     = FETCH;
          count_d   = '0;
          csum_d    = '0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (!tx_busy) begin
          tx_en   = 1'b1;
          guard_d = 1'b1;
          state_d = WAIT_TX;
        end
      end

      WAIT_TX: begin
        // The UART may raise tx_busy a cycle late, so the first cycle is not trusted.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!tx_busy) begin
          state_d = ret_q;
          // Publish the count on entry to FIN so it is valid alongside done.
          if (ret_q == FIN) byte_count_d = count_q;
        end
      end

      FETCH: begin
        if ((count_q == MAX_CNT) || fifo_empty) begin
          state_d = CSUM;
        end else begin
          rd_en   = 1'b1;
          state_d = WAIT_RD;
        end
      end

      WAIT_RD, CSUM: begin
        if ((state_q == CSUM) || fifo_valid) begin
          if (state_q == WAIT_RD) begin
            csum_d  = csum_q + fifo_dout;
            count_d = count_q + CNT_W'(1);
          end
          if (needs_esc(out_byte)) begin
            tx_data_d  = ESC;
            esc_byte_d = out_byte ^ ESC_XOR;
            esc_ret_d  = out_next;
            ret_d      = ESC2;
          end else begin
            tx_data_d  = out_byte;
            ret_d      = out_next;
          end
          state_d = SEND;
        end
      end

      ESC2: begin
        tx_data_d = esc_byte_q;
        ret_d     = esc_ret_q;
        state_d   = SEND;
      end

      EOF_S: begin
        tx_data_d = EOF;
        ret_d     = FIN;
        state_d   = SEND;
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      esc_ret_q  <= IDLE;
      tx_data    <= '0;
      esc_byte_q <= '0;
      csum_q     <= '0;
      count_q    <= '0;
      byte_count <= '0;
      guard_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      ret_q      <= ret_d;
      esc_ret_q  <= esc_ret_d;
      tx_data    <= tx_data_d;
      esc_byte_q <= esc_byte_d;
      csum_q     <= csum_d;
      count_q    <= count_d;
      byte_count <= byte_count_d;
      guard_q    <= guard_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: FIFO and UART behavioural models, a vector
// table of frames with hand-computed byte streams, plus reset/latency sequences.
module tb_uart_frame_tx;

  logic       clk_100 = 1'b0;
  logic       Reset_n, start, fifo_empty, fifo_valid, tx_busy;
  logic       rd_en, tx_en, busy, done;
  logic [7:0] fifo_dout, tx_data;
  logic [8:0] byte_count;

  always #5 clk_100 = ~clk_100;

  uart_frame_tx #(.MAX_LEN(4), .CNT_W(9)) dut (
    .clk_100    (clk_100),
    .Reset_n    (Reset_n),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .rd_en      (rd_en),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  typedef struct {
    bit               clear;
    int               n_in;
    logic [0:5][7:0]  in_b;
    int               lat;
    int               stall;
    bit               mid_start;
    int               n_exp;
    logic [0:9][7:0]  exp_b;
    int               exp_count;
    int               exp_rd;
    bit               exp_empty;
  } vec_t;

  vec_t       vecs [7];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] fifo_q [$];
  logic [7:0] got [$];
  logic [7:0] pend_byte = 8'h00;
  int vld_cnt = 0, busy_cnt = 0, stall = 0, lat = 1;
  int rd_cnt = 0, done_cnt = 0, cyc = 0, last_tx = -10;
  int prop_err = 0, space_err = 0, rd_err = 0;

  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
    end
  endtask

  // Inputs change just after the clock edge, driven from model state.
  always @(posedge clk_100) begin
    #1;
    fifo_empty = (fifo_q.size() == 0);
    fifo_valid = 1'b0;
    if (vld_cnt > 0) begin
      vld_cnt--;
      if (vld_cnt == 0) begin
        fifo_valid = 1'b1;
        fifo_dout  = pend_byte;
      end
    end
    tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  end

  // Outputs are observed mid-cycle.
  always @(negedge clk_100) begin
    cyc++;
    if (tx_en) begin
      if (tx_busy) prop_err++;
      if (cyc - last_tx < 3) space_err++;
      last_tx = cyc;
      got.push_back(tx_data);
      busy_cnt = stall;
    end
    if (rd_en) begin
      rd_cnt++;
      if (vld_cnt > 0) rd_err++;
      if (fifo_q.size() > 0) pend_byte = fifo_q.pop_front();
      vld_cnt = lat;
    end
    if (done) done_cnt++;
  end

  task automatic wait_done();
    for (int c = 0; c < 4000 && done_cnt == 0; c++) @(negedge clk_100);
    repeat (6) @(negedge clk_100);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.clear) fifo_q.delete();
    for (int i = 0; i < v.n_in; i++) fifo_q.push_back(v.in_b[i]);
    stall = v.stall;
    lat   = v.lat;
    repeat (2) @(negedge clk_100);
    got.delete();
    rd_cnt   = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk_100);
    start = 1'b0;
    if (v.mid_start) begin
      repeat (10) @(negedge clk_100);
      start = 1'b1;
      @(negedge clk_100);
      start = 1'b0;
    end
    wait_done();
    check($sformatf("v%0d_len", idx), got.size(), v.n_exp);
    for (int i = 0; i < v.n_exp && i < got.size(); i++)
      check($sformatf("v%0d_byte%0d", idx, i), got[i], v.exp_b[i]);
    check($sformatf("v%0d_byte_count", idx), byte_count, v.exp_count);
    check($sformatf("v%0d_rd_pulses", idx), rd_cnt, v.exp_rd);
    check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d_fifo_empty", idx), fifo_empty, v.exp_empty);
    check($sformatf("v%0d_busy_after", idx), busy, 0);
  endtask

  initial begin
    start      = 1'b0;
    fifo_valid = 1'b0;
    fifo_dout  = 8'h00;
    tx_busy    = 1'b0;
    fifo_empty = 1'b1;
    Reset_n    = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_byte_count", byte_count, 0);
    repeat (3) @(negedge clk_100);
    Reset_n = 1'b1;

    vecs[0] = '{clear:1'b1, n_in:3, in_b:{8'h01, 8'h02, 8'h03, 24'h0}, lat:1, stall:2,
                mid_start:1'b0, n_exp:6, exp_b:{8'hFF, 8'h01, 8'h02, 8'h03, 8'h06, 8'hFE, 32'h0},
                exp_count:3, exp_rd:3, exp_empty:1'b1};
    vecs[1] = '{clear:1'b1, n_in:0, in_b:48'h0, lat:1, stall:0,
                mid_start:1'b0, n_exp:3, exp_b:{8'hFF, 8'h00, 8'hFE, 56'h0},
                exp_count:0, exp_rd:0, exp_empty:1'b1};
    vecs[2] = '{clear:1'b1, n_in:3, in_b:{8'hFF, 8'hFD, 8'hFE, 24'h0}, lat:2, stall:3,
                mid_start:1'b0, n_exp:9,
                exp_b:{8'hFF, 8'hFD, 8'hDF, 8'hFD, 8'hDD, 8'hFD, 8'hDE, 8'hFA, 8'hFE, 8'h00},
                exp_count:3, exp_rd:3, exp_empty:1'b1};
    vecs[3] = '{clear:1'b1, n_in:2, in_b:{8'hFE, 8'h01, 32'h0}, lat:1, stall:1,
                mid_start:1'b0, n_exp:7,
                exp_b:{8'hFF, 8'hFD, 8'hDE, 8'h01, 8'hFD, 8'hDF, 8'hFE, 24'h0},
                exp_count:2, exp_rd:2, exp_empty:1'b1};
    vecs[4] = '{clear:1'b1, n_in:6, in_b:{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15}, lat:1,
                stall:2, mid_start:1'b0, n_exp:7,
                exp_b:{8'hFF, 8'h10, 8'h11, 8'h12, 8'h13, 8'h46, 8'hFE, 24'h0},
                exp_count:4, exp_rd:4, exp_empty:1'b0};
    vecs[5] = '{clear:1'b0, n_in:0, in_b:48'h0, lat:2, stall:2,
                mid_start:1'b0, n_exp:5, exp_b:{8'hFF, 8'h14, 8'h15, 8'h29, 8'hFE, 40'h0},
                exp_count:2, exp_rd:2, exp_empty:1'b1};
    vecs[6] = '{clear:1'b1, n_in:2, in_b:{8'hFD, 8'h40, 32'h0}, lat:1, stall:50,
                mid_start:1'b1, n_exp:6, exp_b:{8'hFF, 8'hFD, 8'hDD, 8'h40, 8'h3D, 8'hFE, 32'h0},
                exp_count:2, exp_rd:2, exp_empty:1'b1};

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

    // Reset in the middle of a payload.
    fifo_q.delete();
    for (int i = 1; i <= 5; i++) fifo_q.push_back(8'(i));
    stall = 2;
    lat   = 1;
    repeat (2) @(negedge clk_100);
    rd_cnt = 0;
    start = 1'b1;
    @(negedge clk_100);
    start = 1'b0;
    for (int c = 0; c < 2000 && rd_cnt < 2; c++) @(negedge clk_100);
    check("mid_rst_reached_payload", (rd_cnt >= 2), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_tx_en", tx_en, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_byte_count", byte_count, 0);
    repeat (3) @(negedge clk_100);
    Reset_n = 1'b1;
    got.delete();
    rd_cnt   = 0;
    done_cnt = 0;
    repeat (30) @(negedge clk_100);
    check("post_rst_no_tx", got.size(), 0);
    check("post_rst_no_rd", rd_cnt, 0);
    check("post_rst_idle", busy, 0);

    // Fresh frame after reset: empty FIFO, SOF exactly one cycle after start.
    fifo_q.delete();
    repeat (2) @(negedge clk_100);
    got.delete();
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk_100);
    start = 1'b0;
    check("sof_latency_tx_en", tx_en, 1);
    check("sof_latency_tx_data", tx_data, 8'hFF);
    check("sof_latency_busy", busy, 1);
    wait_done();
    check("post_rst_len", got.size(), 3);
    if (got.size() == 3) begin
      check("post_rst_b0", got[0], 8'hFF);
      check("post_rst_b1", got[1], 8'h00);
      check("post_rst_b2", got[2], 8'hFE);
    end
    check("post_rst_byte_count", byte_count, 0);
    check("post_rst_done", done_cnt, 1);

    check("tx_en_while_busy", prop_err, 0);
    check("tx_en_spacing", space_err, 0);
    check("rd_outstanding", rd_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Transmit-side framer for the host UART link. It drains the readback FIFO (fifo2) and sends its contents to the host as one framed packet: SOF marker, escaped payload bytes, escaped 8-bit checksum, EOF marker. Each byte goes to the UART transmitter through a tx_en/tx_busy handshake. It sits between fifo2's read port and the UART TX core and is the outbound counterpart of the host command framing, which uses 0xFF to start and 0xFE to end.

## Interface
- SOF, 8'hFF: start-of-frame marker.
- EOF, 8'hFE: end-of-frame marker.
- ESC, 8'hFD: escape marker.
- ESC_XOR, 8'h20: value XORed into an escaped byte.
- MAX_LEN, 256: maximum payload bytes per frame.
- CNT_W, 9: width of the payload counter. Must hold MAX_LEN.

- clk_100  in  1  system clock, 100 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to send one frame. Ignored while busy=1.
- fifo_empty  in  1  fifo2 empty flag.
- fifo_dout  in  8  fifo2 read data.
- fifo_valid  in  1  fifo2 read acknowledge. fifo_dout is valid in this cycle.
- rd_en  out  1  fifo2 read strobe, one cycle wide.
- tx_busy  in  1  UART TX busy.
- tx_data  out  8  byte presented to the UART TX.
- tx_en  out  1  UART TX load strobe, one cycle wide.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the frame is complete.
- byte_count  out  CNT_W  payload bytes in the last frame. Held until the next accepted start.

## Operation
- Reset (Reset_n=0, asynchronous) forces all of the following, in any state including mid-frame:
  - state goes to IDLE;
  - rd_en, tx_en, busy and done go to 0;
  - tx_data and byte_count go to 0;
  - the checksum accumulator clears;
  - no partial frame resumes after reset.
- State machine: IDLE, SEND, WAIT_TX, FETCH, WAIT_RD, ESC2, CSUM, EOF_S, FIN.
- IDLE:
  - start=1 loads SOF into the send register, clears the count and checksum, sets busy and goes to SEND.
- SEND:
  - Waits for tx_busy=0.
  - Then drives tx_data and pulses tx_en for one cycle, and goes to WAIT_TX.
- WAIT_TX:
  - Ignores tx_busy for exactly one cycle as a guard, then waits for tx_busy=0.
  - Then continues to the stored next state.
- FETCH, taken after SOF or after a payload byte completes:
  - If count==MAX_LEN or fifo_empty=1, go to CSUM.
  - Otherwise pulse rd_en for one cycle and go to WAIT_RD.
- WAIT_RD:
  - Holds until fifo_valid=1 and captures fifo_dout in that cycle.
  - Adds the byte to the checksum modulo 256 and increments the count.
  - If the byte is SOF, EOF or ESC, send ESC and then ESC2.
  - Otherwise send the byte directly. Afterwards return to FETCH.
- ESC2: sends byte^ESC_XOR.
- CSUM:
  - Sends the checksum with the same escape rule as payload bytes.
  - The checksum is the sum of the unescaped payload bytes only.
- EOF_S: sends EOF unescaped.
- FIN:
  - Writes the count into byte_count, pulses done, clears busy and returns to IDLE.
- Empty FIFO at start: the frame is SOF, 0x00, EOF, and byte_count=0.
- At most one rd_en is outstanding. A fifo_valid pulse arriving outside WAIT_RD is ignored.

## Timing
- start to first tx_en (SOF) is 1 cycle when tx_busy=0.
- tx_en is only ever asserted in a cycle where tx_busy=0.
- Two tx_en pulses are always at least 3 cycles apart.
- tx_data is stable from the tx_en cycle until the next tx_en.
- rd_en fires 1 cycle after FETCH is entered. Data is taken in the fifo_valid cycle, with any latency of 1 cycle or more.
- done asserts 1 cycle after the WAIT_TX that follows EOF completes. busy falls in the same cycle.
- A start pulse in the same cycle as done is ignored. A new start is accepted from the next cycle.
- tx_busy held high stalls the FSM indefinitely with no lost bytes and no duplicate tx_en.

## Test plan
- Payload 0x01, 0x02, 0x03 in the FIFO, then start. Required: TX sequence FF 01 02 03 06 FE; exactly 3 rd_en pulses; byte_count=3; one done pulse.
- Empty FIFO, then start. Required: FF 00 FE; no rd_en; byte_count=0.
- Payload FF, FD, FE. Required: FF FD DF FD DD FD DE FA FE; byte_count=3.
- Payload FE, 01, giving checksum 0xFF. Required: FF FD DE 01 FD DF FE.
- MAX_LEN=4 with 6 bytes queued. Required: first frame sends 4 payload bytes and fifo_empty stays 0; second start sends the remaining 2 bytes; byte_count is 4, then 2.
- Stall and reset:
  - tx_busy held high for 50 cycles after each tx_en, with start pulsed mid-frame. Required: sequence unchanged and start ignored.
  - Reset_n pulsed low during the payload. Required: all outputs 0 immediately, and IDLE with no further tx_en until the next start.
